// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   state_t      : receiver FSM states
//   DATA_BITS    : payload bits per frame (8N1)
//   OVERSAMPLE   : sample ticks per bit
//   SAMPLE_MID   : centre sample of a bit; the vote uses MID-1, MID and MID+1
//   maj3()       : 2-of-3 majority used for every bit decision
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_MID = 8;

  localparam int TCNT_W = $clog2(OVERSAMPLE);
  localparam int BCNT_W = $clog2(DATA_BITS);

  // Tick positions inside one bit period.
  localparam logic [TCNT_W-1:0] T_EARLY  = TCNT_W'(SAMPLE_MID - 1);
  localparam logic [TCNT_W-1:0] T_MID    = TCNT_W'(SAMPLE_MID);
  localparam logic [TCNT_W-1:0] T_DECIDE = TCNT_W'(SAMPLE_MID + 1);
  localparam logic [TCNT_W-1:0] T_LAST   = TCNT_W'(OVERSAMPLE - 1);

  localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(DATA_BITS - 1);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// -----------------------------------------------------------------------------
// uart_tick_gen
// Free-running divider producing a one-clock tick every DIV clocks.
// Shared between the UART receiver (16x sample tick) and transmitter.
//   clk  : system clock
//   rst  : asynchronous active-high reset (counter back to 0)
//   tick : high for one clk when the counter is at DIV-1
// -----------------------------------------------------------------------------
module uart_tick_gen #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] CNT_LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_os.sv
// -----------------------------------------------------------------------------
// uart_rx_os
// 8N1 UART receiver with 16x oversampling and 3-sample majority decisions.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   rx        : serial line, asynchronous, idle high
//   rx_data   : received byte (LSB first on the line)
//   rx_valid  : rx_data/frame_err valid, held until rx_ready
//   rx_ready  : consumer accept
//   frame_err : stop bit of the held byte was sampled low
//   overrun   : sticky; a frame completed while rx_valid was pending
//   rx_busy   : receiver FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx_os #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  import uart_pkg::*;

  localparam int TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);

  logic              rx_meta;
  logic              rx_s;
  logic              tick;
  state_t            state;
  state_t            state_nxt;
  logic [TCNT_W-1:0] tcnt;
  logic [BCNT_W-1:0] bit_cnt;
  logic [7:0]        shreg;
  logic              smp_early;
  logic              smp_mid;
  logic              armed;
  logic              maj;
  logic              shift_en;
  logic              frame_done;
  logic              accept;

  uart_tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchroniser; resets to the idle line level so reset release
  // never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // The third vote is the live sample at the decision tick.
  assign maj    = maj3(smp_early, smp_mid, rx_s);
  assign accept = rx_valid && rx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first; a missing branch
  // would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    if (tick) begin
      unique case (state)
        IDLE: begin
          if (armed && !rx_s) state_nxt = START;
        end
        START: begin
          // A start bit that is high at its centre was a glitch.
          if (tcnt == T_DECIDE && maj)  state_nxt = IDLE;
          else if (tcnt == T_LAST)      state_nxt = DATA;
        end
        DATA: begin
          if (tcnt == T_DECIDE) shift_en = 1'b1;
          if (tcnt == T_LAST && bit_cnt == BIT_LAST) state_nxt = STOP;
        end
        STOP: begin
          // Finish at the stop-bit centre so the next start edge is caught
          // even when the sender runs fast.
          if (tcnt == T_DECIDE) begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Bit timing and shift datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt      <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      smp_early <= 1'b1;
      smp_mid   <= 1'b1;
      armed     <= 1'b1;
    end else begin
      if (tick) begin
        if (state == IDLE || state_nxt == IDLE) tcnt <= '0;
        else                                    tcnt <= tcnt + 1'b1;

        if (state == START)                          bit_cnt <= '0;
        else if (state == DATA && tcnt == T_LAST)    bit_cnt <= bit_cnt + 1'b1;

        if (tcnt == T_EARLY) smp_early <= rx_s;
        if (tcnt == T_MID)   smp_mid   <= rx_s;
      end

      if (shift_en) shreg <= {maj, shreg[7:1]};

      // After a framing error the line may be in break; require it to return
      // high before another start is taken.
      if (frame_done && !maj) armed <= 1'b0;
      else if (tick && rx_s)  armed <= 1'b1;
    end
  end

  // Output holding register and handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (accept) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
      if (frame_done) begin
        if (!rx_valid || accept) begin
          rx_data   <= shreg;
          frame_err <= !maj;
          rx_valid  <= 1'b1;
        end else begin
          overrun   <= 1'b1;
        end
      end
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_rx_os
// Scoreboard bench for uart_rx_os. Divider scaled to 4 clocks per sample tick
// (64 clocks = 640 ns per bit at a 10 ns clock).
// -----------------------------------------------------------------------------
module tb_uart_rx_os;

  localparam int BIT_NS  = 640;
  localparam int FAST_NS = 621;   // sender 3% fast
  localparam int SLOW_NS = 660;   // sender 3% slow

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  exp_t q[$];
  exp_t mon_e;
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   rx_count = 0;

  always #5 clk = ~clk;

  uart_rx_os #(
    .CLK_FREQ   (640_000),
    .BAUD       (10_000),
    .OVERSAMPLE (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx_busy   (rx_busy)
  );

  // Scoreboard: every accepted byte is popped and compared.
  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      rx_count++;
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_byte: got data=%h ferr=%b, expected no byte", rx_data, frame_err);
      end else begin
        mon_e = q.pop_front();
        if ({rx_data, frame_err} !== {mon_e.data, mon_e.ferr}) begin
          n_fail++;
          $display("FAIL byte: got data=%h ferr=%b, expected data=%h ferr=%b",
                   rx_data, frame_err, mon_e.data, mon_e.ferr);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] d, input logic stop_bit, input int bit_ns);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(bit_ns);
    end
    rx = stop_bit;
    #(bit_ns);
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; rx_ready = 1'b0;
    #23;
    n_tests++;
    if ({rx_data, rx_valid, frame_err, overrun, rx_busy} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, expected 000",
               {rx_data, rx_valid, frame_err, overrun, rx_busy});
    end
    @(negedge clk); rst = 1'b0;
    #(2 * BIT_NS);
  endtask

  task automatic test_nominal();
    int c0 = rx_count;
    rx_ready = 1'b1;
    q.push_back('{data: 8'hA5, ferr: 1'b0});
    send_byte(8'hA5, 1'b1, BIT_NS);
    wait_drain(500);
    n_tests++;
    if (rx_count - c0 !== 1) begin
      n_fail++; $display("FAIL nominal_count: got %0d, expected 1", rx_count - c0);
    end
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("FAIL nominal_overrun: got %b, expected 0", overrun);
    end
    n_tests++;
    if (rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL nominal_valid_clear: got %b, expected 0", rx_valid);
    end
  endtask

  task automatic test_glitch();
    int   c0 = rx_count;
    logic busy_seen = 1'b0;
    rx = 1'b0;
    repeat (12) @(negedge clk) if (rx_busy) busy_seen = 1'b1;
    rx = 1'b1;
    repeat (200) @(negedge clk) if (rx_busy) busy_seen = 1'b1;
    n_tests++;
    if (busy_seen !== 1'b1) begin
      n_fail++; $display("FAIL glitch_busy_seen: got %b, expected 1", busy_seen);
    end
    n_tests++;
    if ({rx_busy, rx_valid} !== 2'b00) begin
      n_fail++; $display("FAIL glitch_idle: got busy/valid=%b, expected 00", {rx_busy, rx_valid});
    end
    n_tests++;
    if (rx_count !== c0) begin
      n_fail++; $display("FAIL glitch_no_byte: got %0d bytes, expected 0", rx_count - c0);
    end
  endtask

  task automatic test_break();
    int   c0 = rx_count;
    logic busy_hold = 1'b0;
    rx_ready = 1'b1;
    q.push_back('{data: 8'h3C, ferr: 1'b1});
    send_byte(8'h3C, 1'b0, BIT_NS);
    repeat (20 * 64) @(negedge clk) if (rx_busy) busy_hold = 1'b1;
    n_tests++;
    if (busy_hold !== 1'b0) begin
      n_fail++; $display("FAIL break_rearm: got busy=%b during low hold, expected 0", busy_hold);
    end
    n_tests++;
    if (rx_count - c0 !== 1) begin
      n_fail++; $display("FAIL break_count: got %0d, expected 1", rx_count - c0);
    end
    rx = 1'b1;
    #(2 * BIT_NS);
    q.push_back('{data: 8'h5A, ferr: 1'b0});
    send_byte(8'h5A, 1'b1, BIT_NS);
    wait_drain(500);
    n_tests++;
    if (q.size() !== 0 || rx_count - c0 !== 2) begin
      n_fail++; $display("FAIL break_after: got %0d bytes, expected 2", rx_count - c0);
    end
  endtask

  task automatic test_overrun();
    int c0 = rx_count;
    rx_ready = 1'b0;
    q.push_back('{data: 8'h11, ferr: 1'b0});
    send_byte(8'h11, 1'b1, BIT_NS);
    send_byte(8'h22, 1'b1, BIT_NS);
    #(BIT_NS);
    @(negedge clk);
    n_tests++;
    if ({rx_valid, rx_data, frame_err, overrun} !== {1'b1, 8'h11, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL overrun_hold: got valid=%b data=%h ferr=%b ovr=%b, expected 1 11 0 1",
               rx_valid, rx_data, frame_err, overrun);
    end
    @(posedge clk); #1 rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({rx_valid, overrun} !== 2'b00) begin
      n_fail++; $display("FAIL overrun_clear: got valid/ovr=%b, expected 00", {rx_valid, overrun});
    end
    n_tests++;
    if (rx_count - c0 !== 1 || q.size() !== 0) begin
      n_fail++; $display("FAIL overrun_count: got %0d, expected 1", rx_count - c0);
    end
  endtask

  task automatic test_back_to_back();
    int rates[2] = '{FAST_NS, SLOW_NS};
    rx_ready = 1'b1;
    foreach (rates[r]) begin
      int c0 = rx_count;
      q.push_back('{data: 8'h00, ferr: 1'b0});
      q.push_back('{data: 8'hFF, ferr: 1'b0});
      q.push_back('{data: 8'h55, ferr: 1'b0});
      send_byte(8'h00, 1'b1, rates[r]);
      send_byte(8'hFF, 1'b1, rates[r]);
      send_byte(8'h55, 1'b1, rates[r]);
      wait_drain(500);
      n_tests++;
      if (rx_count - c0 !== 3 || q.size() !== 0) begin
        n_fail++;
        $display("FAIL back_to_back_%0dns: got %0d bytes, expected 3", rates[r], rx_count - c0);
        q.delete();
      end
      #(2 * BIT_NS);
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    rx_ready = 1'b1;
    fork
      send_byte(8'hC3, 1'b1, BIT_NS);
      begin
        #(5 * BIT_NS + BIT_NS / 2);
        n_tests++;
        if (rx_busy !== 1'b1) begin
          n_fail++; $display("FAIL midframe_busy: got %b, expected 1", rx_busy);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({rx_data, rx_valid, frame_err, overrun, rx_busy} !== 12'h000) begin
          n_fail++;
          $display("FAIL midframe_reset: got %h, expected 000",
                   {rx_data, rx_valid, frame_err, overrun, rx_busy});
        end
      end
    join
    #(BIT_NS);
    n_tests++;
    if ({rx_data, rx_valid, rx_busy} !== 10'h000) begin
      n_fail++; $display("FAIL reset_hold: got %h, expected 000", {rx_data, rx_valid, rx_busy});
    end
    @(negedge clk); rst = 1'b0;
    #(2 * BIT_NS);
    c0 = rx_count;
    q.push_back('{data: 8'h96, ferr: 1'b0});
    send_byte(8'h96, 1'b1, BIT_NS);
    wait_drain(500);
    n_tests++;
    if (rx_count - c0 !== 1 || q.size() !== 0) begin
      n_fail++; $display("FAIL after_reset: got %0d bytes, expected 1", rx_count - c0);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_glitch();
    test_break();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
